// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared types and constants for the GPU shape pipeline.
//   point_t      : packed screen coordinate {x[9:0], y[8:0]}
//   seg_t        : packed line segment {p0, p1}, 38 bits, p0 in the MSBs
//   color_t      : RGB565 colour
//   rast_state_t : line rasterizer FSM states
//   SCREEN_W/H   : visible screen size used as the clip bound
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Bresenham error term width: holds 2*1023 and -2*511 without overflow.
  localparam int ERR_W = 13;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } point_t;

  typedef struct packed {
    point_t p0;
    point_t p1;
  } seg_t;

  typedef logic [15:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } rast_state_t;

endpackage

// File: rtl/line_rasterizer.sv
// -----------------------------------------------------------------------------
// line_rasterizer
// Consumer end of the subshape splitter interface. Latches one line segment
// and its colour, walks it with Bresenham emitting one pixel per cycle to the
// frame-buffer writer, then pulses read so the splitter can advance.
//
// Ports
//   clk          in   system clock
//   n_rst        in   asynchronous active-low reset
//   locations    in   [37:28]=x0 [27:19]=y0 [18:9]=x1 [8:0]=y1
//   color        in   RGB565 colour of the segment
//   seg_valid    in   segment present, held stable until read
//   pixel_stall  in   frame-buffer writer cannot accept this cycle
//   read         out  one-cycle pulse: segment consumed
//   pixel_write  out  pixel_x/pixel_y/pixel_color valid
//   pixel_x      out  pixel x
//   pixel_y      out  pixel y
//   pixel_color  out  pixel colour
//   busy         out  high in every state except IDLE
//
// Configuration macro
//   LINE_RASTER_CLIP_EN : off-screen pixels are still stepped (one cycle each,
//                         stall ignored) but presented with pixel_write=0.
//                         Undefined: every stepped pixel is written.
// -----------------------------------------------------------------------------
module line_rasterizer
  import gpu_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SCREEN_W = gpu_pkg::SCREEN_W,
  parameter int SCREEN_H = gpu_pkg::SCREEN_H
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [2*(X_W+Y_W)-1:0]    locations,
  input  logic [15:0]               color,
  input  logic                      seg_valid,
  input  logic                      pixel_stall,
  output logic                      read,
  output logic                      pixel_write,
  output logic [X_W-1:0]            pixel_x,
  output logic [Y_W-1:0]            pixel_y,
  output logic [15:0]               pixel_color,
  output logic                      busy
);

`ifdef LINE_RASTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  // A pixel is presented as a write unless clipping is built in and it lies off screen.
  function automatic logic f_visible(input point_t p);
    return !CLIP_EN || ((p.x < X_LIM) && (p.y < Y_LIM));
  endfunction

  rast_state_t             r_state;
  seg_t                    r_seg;
  color_t                  r_color;
  point_t                  r_cur;
  logic signed [ERR_W-1:0] r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sx_neg;
  logic                    r_sy_neg;

  logic [9:0]              w_dx_abs;
  logic [8:0]              w_dy_abs;
  logic signed [ERR_W-1:0] w_dx_ld;
  logic signed [ERR_W-1:0] w_dy_ld;
  logic signed [ERR_W-1:0] w_e2;
  logic signed [ERR_W-1:0] w_err_nxt;
  logic                    w_step_x;
  logic                    w_step_y;
  point_t                  w_nxt;
  logic                    w_at_end;
  logic                    w_hold;

  assign busy = (r_state != ST_IDLE);

  // Segment setup, evaluated from the latched endpoints during LOAD.
  assign w_dx_abs = (r_seg.p1.x >= r_seg.p0.x) ? (r_seg.p1.x - r_seg.p0.x)
                                               : (r_seg.p0.x - r_seg.p1.x);
  assign w_dy_abs = (r_seg.p1.y >= r_seg.p0.y) ? (r_seg.p1.y - r_seg.p0.y)
                                               : (r_seg.p0.y - r_seg.p1.y);
  assign w_dx_ld  = $signed({3'b000, w_dx_abs});
  assign w_dy_ld  = -$signed({4'b0000, w_dy_abs});

  // One Bresenham step; x and y may both advance in the same cycle.
  assign w_e2      = r_err <<< 1;
  assign w_step_x  = (w_e2 >= r_dy);
  assign w_step_y  = (w_e2 <= r_dx);
  assign w_err_nxt = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
  assign w_nxt.x   = w_step_x ? (r_sx_neg ? r_cur.x - 10'd1 : r_cur.x + 10'd1) : r_cur.x;
  assign w_nxt.y   = w_step_y ? (r_sy_neg ? r_cur.y - 9'd1 : r_cur.y + 9'd1) : r_cur.y;
  assign w_at_end  = (r_cur == r_seg.p1);

  // Stall only freezes a pixel that is actually being written; a clipped
  // pixel has pixel_write=0 and so always advances after one cycle.
  assign w_hold = pixel_stall & pixel_write;

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      read        <= 1'b0;
      pixel_write <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          read        <= 1'b0;
          pixel_write <= 1'b0;
          if (seg_valid) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_state     <= ST_DRAW;
          pixel_write <= f_visible(r_seg.p0);
          pixel_x     <= r_seg.p0.x;
          pixel_y     <= r_seg.p0.y;
          pixel_color <= r_color;
        end
        ST_DRAW: begin
          if (!w_hold) begin
            if (w_at_end) begin
              r_state     <= ST_DONE;
              pixel_write <= 1'b0;
              read        <= 1'b1;
            end else begin
              pixel_write <= f_visible(w_nxt);
              pixel_x     <= w_nxt.x;
              pixel_y     <= w_nxt.y;
            end
          end
        end
        ST_DONE: begin
          read    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers; always reloaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: begin
        if (seg_valid) begin
          r_seg   <= seg_t'(locations);
          r_color <= color;
        end
      end
      ST_LOAD: begin
        r_dx     <= w_dx_ld;
        r_dy     <= w_dy_ld;
        r_err    <= w_dx_ld + w_dy_ld;
        r_sx_neg <= (r_seg.p1.x < r_seg.p0.x);
        r_sy_neg <= (r_seg.p1.y < r_seg.p0.y);
        r_cur    <= r_seg.p0;
      end
      ST_DRAW: begin
        if (!w_hold && !w_at_end) begin
          r_err <= w_err_nxt;
          r_cur <= w_nxt;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// -----------------------------------------------------------------------------
// tb_line_rasterizer
// Scoreboard bench for line_rasterizer. The driver computes each segment's
// pixel sequence with a plain integer Bresenham walk and queues it; a monitor
// pops and compares every accepted pixel and, on each read pulse, the number
// of pixels written for that segment. Honors LINE_RASTER_CLIP_EN.
// -----------------------------------------------------------------------------
module tb_line_rasterizer;

  localparam int LIMIT = 4000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [37:0] locations;
  logic [15:0] color;
  logic        seg_valid;
  logic        pixel_stall;
  logic        read;
  logic        pixel_write;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [15:0] pixel_color;
  logic        busy;

  line_rasterizer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .locations   (locations),
    .color       (color),
    .seg_valid   (seg_valid),
    .pixel_stall (pixel_stall),
    .read        (read),
    .pixel_write (pixel_write),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   cnt_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   mon_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
    return (x < 640) && (y < 480);
`else
    return 1'b1;
`endif
  endfunction

  // Reference walk: queues every pixel that should be written and the count
  // expected at read; returns the number of stepped pixels (written or not).
  function automatic int model(input int x0, input int y0, input int x1, input int y1,
                               input logic [15:0] c);
    int dx, dy, sx, sy, err, e2, x, y, n, w;
    pix_t p;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0; n = 0; w = 0;
    while (1) begin
      n++;
      if (on_screen(x, y)) begin
        p.x = x; p.y = y; p.c = c;
        exp_q.push_back(p);
        w++;
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    cnt_q.push_back(w);
    return n;
  endfunction

  // Monitor: compares each accepted pixel and each read pulse.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        mon_cnt = 0;
      end else begin
        if (pixel_write && !pixel_stall) begin
          if (exp_q.size() == 0) begin
            chk("unexpected pixel x", int'(pixel_x), -1);
          end else begin
            e = exp_q.pop_front();
            chk("pixel x", int'(pixel_x), e.x);
            chk("pixel y", int'(pixel_y), e.y);
            chk("pixel color", int'(pixel_color), int'(e.c));
          end
          mon_cnt++;
        end
        if (read) begin
          if (cnt_q.size() == 0) chk("unexpected read", 1, 0);
          else chk("pixels per segment", mon_cnt, cnt_q.pop_front());
          mon_cnt = 0;
        end
      end
    end
  end

  // stall_mode: 0 none, 1 random, 2 stall the second pixel for 3 cycles.
  // exp_lat < 0 skips the read latency check.
  task automatic run_seg(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] c, input int stall_mode, input int exp_lat);
    int n, got;
    n = model(x0, y0, x1, y1, c);
    locations = {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
    color     = c;
    seg_valid = 1'b1;
    got = -1;
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       pixel_stall = ($urandom_range(0, 3) == 0);
        2:       pixel_stall = (cyc >= 2 && cyc <= 4);
        default: pixel_stall = 1'b0;
      endcase
      @(negedge clk);
      if (cyc == 0) chk("busy in LOAD", int'(busy), 1);
      if (stall_mode == 2 && cyc >= 2 && cyc <= 5) chk("stalled pixel held", int'(pixel_x), 1);
      if (read) begin
        got = cyc;
        break;
      end
    end
    if (got < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL read timeout: no read within %0d cycles, expected after %0d pixels", LIMIT, n);
    end else if (exp_lat >= 0) begin
      chk("read latency", got, exp_lat);
    end
    @(posedge clk);
    #1;
    pixel_stall = 1'b0;
    chk("busy after read", int'(busy), 0);
  endtask

  initial begin
    int any_read;
    int x0, y0, x1, y1, len, kind;
    n_rst       = 1'b0;
    locations   = '0;
    color       = '0;
    seg_valid   = 1'b0;
    pixel_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pixel_write", int'(pixel_write), 0);
    chk("reset read", int'(read), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pixel_x", int'(pixel_x), 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed segments.
    run_seg(0, 0, 3, 0, 16'hF800, 0, 5);
    run_seg(0, 0, 1, 3, 16'h07E0, 0, 5);
    run_seg(5, 5, 2, 2, 16'h001F, 0, 5);
    run_seg(7, 9, 7, 9, 16'h1234, 0, 2);
    run_seg(0, 0, 3, 0, 16'hF800, 2, 8);
    run_seg(638, 0, 641, 0, 16'hABCD, 0, 5);
    seg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while (2,0) is presented on a 0..9 horizontal line.
    begin
      pix_t p;
      for (int i = 0; i < 3; i++) begin
        p.x = i; p.y = 0; p.c = 16'h5A5A;
        exp_q.push_back(p);
      end
    end
    locations = {10'd0, 9'd0, 10'd9, 9'd0};
    color     = 16'h5A5A;
    seg_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk("pixel before reset", int'(pixel_x), 2);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid-line reset pixel_write", int'(pixel_write), 0);
    chk("mid-line reset pixel_x", int'(pixel_x), 0);
    chk("mid-line reset pixel_color", int'(pixel_color), 0);
    chk("mid-line reset busy", int'(busy), 0);
    seg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    any_read = 0;
    repeat (4) begin
      @(negedge clk);
      if (read) any_read = 1;
    end
    chk("no read after reset", any_read, 0);
    @(posedge clk);
    #1;
    run_seg(4, 3, 6, 3, 16'h0F0F, 0, 4);

    // Randomized segments, back to back, with random stalls.
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        x0 = $urandom_range(0, 31); y0 = $urandom_range(0, 31);
        x1 = $urandom_range(0, 31); y1 = $urandom_range(0, 31);
      end else if (kind < 8) begin
        x0 = $urandom_range(630, 650); y0 = $urandom_range(470, 490);
        x1 = $urandom_range(630, 650); y1 = $urandom_range(470, 490);
      end else begin
        x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 511);
        x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 511);
      end
      if ($urandom_range(0, 7) == 0) begin
        x1 = x0; y1 = y0;
      end
      len = $urandom_range(0, 1);
      run_seg(x0, y0, x1, y1, 16'($urandom), len, -1);
    end
    seg_valid = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("leftover expected pixels", exp_q.size(), 0);
    chk("leftover expected reads", cnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
